// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RV32 pipeline hazard logic.
// Holds the freeze-FSM state encoding, forwarding-select codes, the x0
// register index, the stall/flush strobe bundle and the load-use helper.
package riscv_pipe_pkg;

  localparam int unsigned REG_W  = 5;   // register index width
  localparam int unsigned FWD_W  = 2;   // forwarding select width
  localparam int unsigned WDOG_W = 16;  // watchdog counter width (MEM_TIMEOUT <= 2^16-1)

  // Freeze FSM: RUN is normal flow, MEMWAIT holds the pipe on a slow data access
  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } pipeState_t;

  // Execute-stage operand sources
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  // Stall/flush strobes driven to the stage registers
  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hazardCtl_t;

  // Load in Execute whose destination is read by the instruction in Decode
  function automatic logic loadUse(
    input logic             isLoadE,
    input logic [REG_W-1:0] rdE,
    input logic [REG_W-1:0] rs1D,
    input logic [REG_W-1:0] rs2D
  );
    return isLoadE && (rdE != REG_X0) && ((rdE == rs1D) || (rdE == rs2D));
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: forwarding select for one execute-stage operand.
// Ports:
//   RsE                  source register of the operand in Execute
//   RdM, RdW             destination registers in Memory / Writeback
//   RegWriteM, RegWriteW register-write enables in Memory / Writeback
//   Forward              FWD_MEM, FWD_WB or FWD_RF (combinational)
// The Memory stage holds the younger result, so it wins over Writeback.
// x0 is hard-wired to zero and is never forwarded.
module fwd_sel
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [FWD_W-1:0] Forward
);

  // Priority select: Memory, then Writeback, then register file
  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && (RdM != REG_X0) && (RdM == RsE)) begin
      Forward = FWD_MEM;
    end else if (RegWriteW && (RdW != REG_X0) && (RdW == RsE)) begin
      Forward = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
// Generates execute-stage forwarding selects, load-use / branch stall and
// flush strobes, and freezes the pipe while data memory is not ready.
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   Rs1D, Rs2D                   Decode source registers
//   Rs1E, Rs2E                   Execute source registers
//   RdE, RdM, RdW                Execute / Memory / Writeback destinations
//   ResultSrcE                   instruction in Execute is a load
//   RegWriteM, RegWriteW         Memory / Writeback write enables
//   PCSrcE                       taken branch/jump resolved in Execute
//   dmem_req, dmem_ready         data-memory request / completion
//   ForwardAE, ForwardBE         operand selects (combinational)
//   StallF/D/E/M, FlushD/E/W     stage-register strobes (combinational, 0 in reset)
//   mem_timeout                  sticky watchdog flag, cleared only by reset
//   stall_cnt, flush_cnt         perf counters (HAZARD_PERF_EN only)
// Build option: define HAZARD_PERF_EN to add the CNT_W parameter and the
// stall/flush performance counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [FWD_W-1:0] ForwardAE,
  output logic [FWD_W-1:0] ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(MEM_TIMEOUT);

  // Elaboration-time range check on the watchdog limit
  if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 65535)) begin : g_badTimeout
    $error("hazard_ctrl: MEM_TIMEOUT out of range 1..65535");
  end

  pipeState_t        state;
  pipeState_t        stateNext;
  logic [WDOG_W-1:0] wdogCnt;
  logic [WDOG_W-1:0] wdogNext;
  logic              freeze;
  logic              lwStall;
  hazardCtl_t        ctl;

  // Operand forwarding, one selector per execute operand
  fwd_sel u_fwdA (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardAE)
  );

  fwd_sel u_fwdB (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardBE)
  );

  assign lwStall = loadUse(ResultSrcE, RdE, Rs1D, Rs2D);

  // State register, watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wdogCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      wdogCnt <= wdogNext;
      if (wdogNext == WDOG_LIMIT) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Next state and strobes. The freeze covers the entry cycle (still RUN)
  // and every MEMWAIT cycle without ready; the ready cycle releases with
  // the RUN equations so the memory wait costs no extra cycle.
  always_comb begin
    stateNext = state;
    freeze    = 1'b0;
    ctl       = '0;

    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          stateNext = MEMWAIT;
          freeze    = 1'b1;
        end
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          stateNext = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase

    // Strobes are forced low while reset is held, independent of the clock
    if (!rst) begin
      ctl = '0;
    end else if (freeze) begin
      // Hold everything up to Memory and bubble Writeback; hazards wait
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.stallM = 1'b1;
      ctl.flushW = 1'b1;
    end else begin
      // A taken branch squashes the dependent instruction, so no stall needed
      ctl.stallF = lwStall && !PCSrcE;
      ctl.stallD = lwStall && !PCSrcE;
      ctl.flushE = lwStall || PCSrcE;
      ctl.flushD = PCSrcE;
    end
  end

  // Watchdog holds the number of cycles spent in MEMWAIT, saturating at the limit
  always_comb begin
    wdogNext = '0;
    if (stateNext == MEMWAIT) begin
      wdogNext = (wdogCnt == WDOG_LIMIT) ? wdogCnt : wdogCnt + WDOG_W'(1);
    end
  end

  assign StallF = ctl.stallF;
  assign StallD = ctl.stallD;
  assign StallE = ctl.stallE;
  assign StallM = ctl.stallM;
  assign FlushD = ctl.flushD;
  assign FlushE = ctl.flushE;
  assign FlushW = ctl.flushW;

`ifdef HAZARD_PERF_EN
  logic anyStall;
  logic anyFlush;

  assign anyStall = ctl.stallF || ctl.stallD || ctl.stallE || ctl.stallM;
  assign anyFlush = ctl.flushD || ctl.flushE;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (anyStall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (anyFlush) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch override,
// memory freeze/release, watchdog timeout and reset, and (with
// HAZARD_PERF_EN) the performance counters.
module tb_hazard_ctrl;
  import riscv_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int nVec = 0;
  int nMis = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  logic [6:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] CTL_IDLE   = 7'b0000_000;
  localparam logic [6:0] CTL_LWS    = 7'b1100_010;
  localparam logic [6:0] CTL_BR     = 7'b0000_110;
  localparam logic [6:0] CTL_FREEZE = 7'b1111_001;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .ResultSrcE  (ResultSrcE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .PCSrcE      (PCSrcE),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       rwM;
    logic       rwW;
    logic [1:0] expA;
    logic [1:0] expB;
  } fwdVec_t;

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and leave the design in RUN
  task automatic pulse_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    // Hazard-producing inputs must be masked while reset is held
    ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE);
    end
    nVec++;
    if (mem_timeout !== 1'b0) begin
      nMis++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
    end
    step();
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL reset_ctl_clk: got %b expected %b", ctl, CTL_IDLE);
    end
    clear_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_forward();
    fwdVec_t vecs [7];
    vecs = '{
      '{5'd5,  5'd9,  5'd5,  5'd5,  1'b1, 1'b1, 2'b10, 2'b00},
      '{5'd5,  5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 2'b01, 2'b00},
      '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00},
      '{5'd5,  5'd5,  5'd5,  5'd5,  1'b0, 1'b1, 2'b01, 2'b01},
      '{5'd5,  5'd6,  5'd5,  5'd6,  1'b1, 1'b1, 2'b10, 2'b01},
      '{5'd5,  5'd6,  5'd5,  5'd6,  1'b0, 1'b0, 2'b00, 2'b00},
      '{5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 2'b10, 2'b10}
    };
    clear_inputs();
    for (int i = 0; i < 7; i++) begin
      Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
      RdM = vecs[i].rdM; RdW = vecs[i].rdW;
      RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
      #1;
      nVec++;
      if (ForwardAE !== vecs[i].expA) begin
        nMis++; $display("FAIL fwdA[%0d]: got %b expected %b", i, ForwardAE, vecs[i].expA);
      end
      nVec++;
      if (ForwardBE !== vecs[i].expB) begin
        nMis++; $display("FAIL fwdB[%0d]: got %b expected %b", i, ForwardBE, vecs[i].expB);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ResultSrcE = 1'b1; RdE = 5'd7; Rs1D = 5'd3; Rs2D = 5'd7;
    #1;
    nVec++;
    if (ctl !== CTL_LWS) begin
      nMis++; $display("FAIL lwstall_rs2: got %b expected %b", ctl, CTL_LWS);
    end
    step();
    // FlushE turned the load's successor into a bubble
    ResultSrcE = 1'b0; RdE = 5'd0;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL lwstall_one_cycle: got %b expected %b", ctl, CTL_IDLE);
    end
    ResultSrcE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd0;
    #1;
    nVec++;
    if (ctl !== CTL_LWS) begin
      nMis++; $display("FAIL lwstall_rs1: got %b expected %b", ctl, CTL_LWS);
    end
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL lwstall_x0: got %b expected %b", ctl, CTL_IDLE);
    end
    ResultSrcE = 1'b0; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL lwstall_noload: got %b expected %b", ctl, CTL_IDLE);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    #1;
    nVec++;
    if (ctl !== CTL_BR) begin
      nMis++; $display("FAIL branch_over_lw: got %b expected %b", ctl, CTL_BR);
    end
    ResultSrcE = 1'b0;
    #1;
    nVec++;
    if (ctl !== CTL_BR) begin
      nMis++; $display("FAIL branch_only: got %b expected %b", ctl, CTL_BR);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_memwait();
    clear_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      // Hazards arriving mid-freeze must be ignored
      if (c == 1) begin
        ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        Rs1E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1;
      end
      #1;
      nVec++;
      if (ctl !== CTL_FREEZE) begin
        nMis++; $display("FAIL freeze_cycle%0d: got %b expected %b", c, ctl, CTL_FREEZE);
      end
      if (c == 1) begin
        nVec++;
        if (ForwardAE !== FWD_MEM) begin
          nMis++; $display("FAIL fwd_in_freeze: got %b expected %b", ForwardAE, FWD_MEM);
        end
        ResultSrcE = 1'b0; RdE = 5'd0; Rs2D = 5'd0; PCSrcE = 1'b0;
        Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b0;
      end
      step();
    end
    dmem_ready = 1'b1;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL release_cycle: got %b expected %b", ctl, CTL_IDLE);
    end
    step();
    // Only RUN leaves the pipe moving with no request pending
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL back_in_run: got %b expected %b", ctl, CTL_IDLE);
    end
    nVec++;
    if (mem_timeout !== 1'b0) begin
      nMis++; $display("FAIL short_wait_timeout: got %b expected 0", mem_timeout);
    end
    // Request completing in the same cycle: no freeze, stay in RUN
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL req_ready_same: got %b expected %b", ctl, CTL_IDLE);
    end
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL req_ready_stays_run: got %b expected %b", ctl, CTL_IDLE);
    end
    // Release cycle applies RUN equations: a taken branch flushes immediately
    dmem_req = 1'b1;
    step();
    dmem_ready = 1'b1; PCSrcE = 1'b1;
    #1;
    nVec++;
    if (ctl !== CTL_BR) begin
      nMis++; $display("FAIL release_branch: got %b expected %b", ctl, CTL_BR);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    pulse_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    // Cycle 0 is the entry cycle, cycles 1..5 are MEMWAIT cycles
    for (int c = 0; c < 6; c++) begin
      #1;
      nVec++;
      if (mem_timeout !== (c >= 4)) begin
        nMis++; $display("FAIL timeout_cycle%0d: got %b expected %b", c, mem_timeout, (c >= 4));
      end
      step();
    end
    #1;
    nVec++;
    if (ctl !== CTL_FREEZE) begin
      nMis++; $display("FAIL frozen_after_timeout: got %b expected %b", ctl, CTL_FREEZE);
    end
    rst = 1'b0;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL async_reset_ctl: got %b expected %b", ctl, CTL_IDLE);
    end
    nVec++;
    if (mem_timeout !== 1'b0) begin
      nMis++; $display("FAIL async_reset_timeout: got %b expected 0", mem_timeout);
    end
    clear_inputs();
    step();
    rst = 1'b1;
    #1;
    nVec++;
    if (ctl !== CTL_IDLE) begin
      nMis++; $display("FAIL post_reset_run: got %b expected %b", ctl, CTL_IDLE);
    end
    step();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    pulse_reset();
    nVec++;
    if ((stall_cnt !== 32'd0) || (flush_cnt !== 32'd0)) begin
      nMis++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) step();
    dmem_ready = 1'b1;
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0; PCSrcE = 1'b1;
    step();
    clear_inputs();
    step();
    nVec++;
    if (stall_cnt !== 32'd3) begin
      nMis++; $display("FAIL perf_stall_cnt: got %0d expected 3", stall_cnt);
    end
    nVec++;
    if (flush_cnt !== 32'd1) begin
      nMis++; $display("FAIL perf_flush_cnt: got %0d expected 1", flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_memwait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
